apb_uart_rx: RTL and testbench

//  APB slave UART receiver; sibling of the UART TX slave on the shared APB bus behind the interconnect.

---
 rtl/apb_uart_rx_pkg.sv | 31 +++
 rtl/apb_uart_rx_fifo.sv | 68 ++++++
 rtl/apb_uart_rx.sv | 210 +++++++++++++++++++++
 tb/tb_apb_uart_rx.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_uart_rx_pkg.sv
// Shared definitions for the APB UART receiver.
//   Register offsets (PADDR[1:0]), STATUS bit positions, minimum divisor,
//   RX FSM state type and the divisor clamp helper.
package apb_uart_rx_pkg;

  // Register offsets, decoded from PADDR[1:0]
  localparam logic [1:0] UART_RX_DATA   = 2'd0;
  localparam logic [1:0] UART_RX_STATUS = 2'd1;
  localparam logic [1:0] UART_RX_BAUD   = 2'd2;

  // STATUS bit positions; count occupies [3:0]
  localparam int unsigned STAT_OVR   = 7;
  localparam int unsigned STAT_FERR  = 6;
  localparam int unsigned STAT_FULL  = 5;
  localparam int unsigned STAT_EMPTY = 4;

  // Smallest divisor that still leaves room for a mid-bit sample
  localparam logic [15:0] MIN_DIV = 16'd4;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_t;

  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < MIN_DIV) ? MIN_DIV : v;
  endfunction

endpackage

// File: rtl/apb_uart_rx_fifo.sv
// Synchronous FIFO shared by the UART slaves.
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   push, wdata    write request and data; dropped when full unless a pop coincides
//   pop, rdata     read request (ignored when empty); rdata shows the head entry
//   full, empty    level flags
//   count          occupancy 0..DEPTH
//   overflow       pulse: push was dropped this cycle
module apb_uart_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow
);

  localparam logic [AW:0] DepthC = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == DepthC);
  assign do_pop   = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign do_push  = push & (~full | do_pop);
  assign overflow = push & full & ~do_pop;
  assign rdata    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/apb_uart_rx.sv
// APB slave UART receiver (8N1, programmable divisor, RX FIFO).
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   S_PADDR..S_PWDATA           APB slave inputs; only PADDR[1:0] decoded
//   S_PRDATA, S_PREADY          APB read data and ready (zero wait state)
//   rx                          asynchronous serial input, idle high
//   irq                         registered, high while the FIFO holds data
// Registers: 0 DATA (read pops), 1 STATUS (write 1 to bit7/6 clears ovr/ferr),
//            2 BAUD (clocks per bit, clamped to MIN_DIV), 3 reserved.
module apb_uart_rx
  import apb_uart_rx_pkg::*;
#(
  parameter int unsigned DEFAULT_DIV = 434,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned FIFO_AW     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] S_PADDR,
  input  logic        S_PWRITE,
  input  logic        S_PSELx,
  input  logic        S_PENABLE,
  input  logic [15:0] S_PWDATA,
  output logic [15:0] S_PRDATA,
  output logic        S_PREADY,
  input  logic        rx,
  output logic        irq
);

  localparam logic [15:0] DefaultDivC = 16'(DEFAULT_DIV);

  logic [1:0]  addr;
  logic        access;
  logic        rd_access;
  logic        wr_access;
  logic        unused_paddr;

  logic [15:0] baud;
  logic        ovr;
  logic        ferr;

  logic        rx_meta;
  logic        rx_s;

  rx_state_t   state;
  logic [15:0] cnt;
  logic [15:0] div_l;
  logic [2:0]  bi;
  logic [7:0]  shreg;

  logic         fifo_push;
  logic         fifo_pop;
  logic [7:0]   fifo_head;
  logic         fifo_full;
  logic         fifo_empty;
  logic [FIFO_AW:0] fifo_count;
  logic         fifo_ovf;
  logic         ferr_set;

  assign addr         = S_PADDR[1:0];
  assign unused_paddr = ^S_PADDR[15:2];
  assign access       = S_PSELx & S_PENABLE;
  assign rd_access    = access & ~S_PWRITE;
  assign wr_access    = access & S_PWRITE;
  assign S_PREADY     = access;

  // Only the access phase of a DATA read pops; the FIFO ignores pops when empty
  assign fifo_pop  = rd_access & (addr == UART_RX_DATA);
  assign fifo_push = (state == StStop) & (cnt == '0) & rx_s;
  assign ferr_set  = (state == StStop) & (cnt == '0) & ~rx_s;

  apb_uart_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .wdata    (shreg),
    .pop      (fifo_pop),
    .rdata    (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .overflow (fifo_ovf)
  );

  always_comb begin
    S_PRDATA = 16'h0000;
    if (rd_access) begin
      case (addr)
        UART_RX_DATA:   S_PRDATA = fifo_empty ? 16'h0000 : {8'h00, fifo_head};
        UART_RX_STATUS: begin
          S_PRDATA[STAT_OVR]   = ovr;
          S_PRDATA[STAT_FERR]  = ferr;
          S_PRDATA[STAT_FULL]  = fifo_full;
          S_PRDATA[STAT_EMPTY] = fifo_empty;
          S_PRDATA[3:0]        = 4'(fifo_count);
        end
        UART_RX_BAUD:   S_PRDATA = baud;
        default:        S_PRDATA = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      baud <= DefaultDivC;
    end else if (wr_access && (addr == UART_RX_BAUD)) begin
      baud <= clamp_div(S_PWDATA);
    end
  end

  // Sticky error flags; a set in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      if (fifo_ovf) begin
        ovr <= 1'b1;
      end else if (wr_access && (addr == UART_RX_STATUS) && S_PWDATA[STAT_OVR]) begin
        ovr <= 1'b0;
      end
      if (ferr_set) begin
        ferr <= 1'b1;
      end else if (wr_access && (addr == UART_RX_STATUS) && S_PWDATA[STAT_FERR]) begin
        ferr <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= (fifo_count != '0);
    end
  end

  // Receive FSM. cnt counts down to the next mid-bit sample point; the divisor is
  // latched at the start bit so BAUD writes never disturb a frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= StIdle;
      cnt   <= '0;
      div_l <= DefaultDivC;
      bi    <= '0;
      shreg <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (!rx_s) begin
            state <= StStart;
            cnt   <= baud >> 1;
            div_l <= baud;
          end
        end
        StStart: begin
          if (cnt == '0) begin
            if (!rx_s) begin
              state <= StData;
              cnt   <= div_l - 16'd1;
              bi    <= '0;
            end else begin
              // Start bit vanished by mid-bit: treat as a glitch
              state <= StIdle;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        StData: begin
          if (cnt == '0) begin
            shreg[bi] <= rx_s;
            cnt       <= div_l - 16'd1;
            if (bi == 3'd7) begin
              state <= StStop;
            end else begin
              bi <= bi + 3'd1;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        StStop: begin
          // Push or framing error is decoded combinationally from this state
          if (cnt == '0) begin
            state <= StIdle;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_uart_rx.sv
module tb_apb_uart_rx;

  logic        clk;
  logic        reset;
  logic [15:0] paddr;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [15:0] pwdata;
  logic [15:0] prdata;
  logic        pready;
  logic        rx;
  logic        irq;

  int checks;
  int failures;
  int baud;

  // Reference model: byte queue plus sticky flags
  logic [7:0] mq[$];
  logic       m_ovr;
  logic       m_ferr;

  logic [15:0] rd;
  logic        rdy;
  logic [7:0]  b;
  logic        ok;
  int          n;

  apb_uart_rx dut (
    .clk       (clk),
    .reset     (reset),
    .S_PADDR   (paddr),
    .S_PWRITE  (pwrite),
    .S_PSELx   (psel),
    .S_PENABLE (penable),
    .S_PWDATA  (pwdata),
    .S_PRDATA  (prdata),
    .S_PREADY  (pready),
    .rx        (rx),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_status();
    logic [15:0] s;
    s      = 16'h0;
    s[7]   = m_ovr;
    s[6]   = m_ferr;
    s[5]   = (mq.size() == 8);
    s[4]   = (mq.size() == 0);
    s[3:0] = 4'(mq.size());
    return s;
  endfunction

  function automatic void model_rx(input logic [7:0] v, input logic stop_ok);
    if (!stop_ok) m_ferr = 1'b1;
    else if (mq.size() < 8) mq.push_back(v);
    else m_ovr = 1'b1;
  endfunction

  function automatic logic [15:0] model_pop();
    if (mq.size() == 0) return 16'h0;
    return {8'h00, mq.pop_front()};
  endfunction

  // All bus tasks start just after a rising edge and return just after one
  task automatic apb_write(input logic [1:0] a, input logic [15:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = {14'h0, a}; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [1:0] a, output logic [15:0] d, output logic r);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = {14'h0, a};
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    d = prdata;
    r = pready;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] v, input logic stop_ok);
    rx = 1'b0;
    repeat (baud) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = v[i];
      repeat (baud) @(posedge clk);
      #1;
    end
    rx = stop_ok;
    repeat (baud) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (baud) @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    apb_read(2'd1, rd, rdy);
    check_eq(tag, rd, model_status());
  endtask

  task automatic check_irq(input string tag);
    @(posedge clk); #1;
    check_eq(tag, {15'h0, irq}, {15'h0, (mq.size() != 0)});
  endtask

  task automatic set_baud(input int v);
    apb_write(2'd2, 16'(v));
    baud = (v < 4) ? 4 : v;
    apb_read(2'd2, rd, rdy);
    check_eq("baud_rb", rd, 16'(baud));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete();
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    baud = 434;
  endtask

  initial begin
    checks = 0; failures = 0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    rx = 1'b1; reset = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Reset state
    check_eq("rst_prdata", prdata, 16'h0);
    check_eq("rst_pready", {15'h0, pready}, 16'h0);
    check_eq("rst_irq", {15'h0, irq}, 16'h0);
    apb_read(2'd2, rd, rdy);
    check_eq("rst_baud", rd, 16'h01B2);
    check_eq("pready_acc", {15'h0, rdy}, 16'h1);
    check_status("rst_status");
    apb_read(2'd3, rd, rdy);
    check_eq("reg3", rd, 16'h0);

    // Single byte
    set_baud(16);
    send_frame(8'hA5, 1'b1);
    model_rx(8'hA5, 1'b1);
    check_irq("irq_a5");
    check_status("stat_a5");
    apb_read(2'd0, rd, rdy);
    check_eq("data_a5", rd, model_pop());
    check_status("stat_a5_pop");
    check_irq("irq_a5_pop");

    // Overflow: nine bytes with no reads
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b1);
      model_rx(8'(i), 1'b1);
    end
    check_status("stat_ovr");
    for (int i = 0; i < 9; i++) begin
      apb_read(2'd0, rd, rdy);
      check_eq("data_drain", rd, model_pop());
    end
    apb_write(2'd1, 16'h0080);
    m_ovr = 1'b0;
    check_status("stat_ovr_clr");

    // Framing error leaves the FIFO alone
    send_frame(8'h11, 1'b1);
    model_rx(8'h11, 1'b1);
    send_frame(8'h3C, 1'b0);
    model_rx(8'h3C, 1'b0);
    check_status("stat_ferr");
    apb_write(2'd1, 16'h0040);
    m_ferr = 1'b0;
    check_status("stat_ferr_clr");

    // Glitch on idle line
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_status("stat_glitch");
    set_baud(2);
    set_baud(16);

    // Pop coinciding with the stop-bit push into a full FIFO
    while (mq.size() < 8) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      model_rx(b, 1'b1);
    end
    check_status("stat_full");
    b = 8'($urandom);
    fork
      send_frame(b, 1'b1);
      begin
        // Stop sample lands 4 + baud/2 + 9*baud edges after the start-bit drive
        repeat (2 + baud / 2 + 9 * baud) @(posedge clk);
        #1;
        apb_read(2'd0, rd, rdy);
      end
    join
    check_eq("data_pp", rd, model_pop());
    model_rx(b, 1'b1);
    check_status("stat_pp");
    while (mq.size() > 0) begin
      apb_read(2'd0, rd, rdy);
      check_eq("data_pp_drain", rd, model_pop());
    end

    // Randomised rounds
    for (int r = 0; r < 5; r++) begin
      set_baud($urandom_range(8, 24));
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) begin
        b  = 8'($urandom);
        ok = ($urandom_range(0, 5) != 0);
        send_frame(b, ok);
        model_rx(b, ok);
      end
      check_status("rnd_stat");
      n = $urandom_range(0, 9);
      for (int i = 0; i < n; i++) begin
        apb_read(2'd0, rd, rdy);
        check_eq("rnd_data", rd, model_pop());
      end
      check_irq("rnd_irq");
      pwdata = 16'($urandom_range(0, 3)) << 6;
      apb_write(2'd1, pwdata);
      if (pwdata[7]) m_ovr = 1'b0;
      if (pwdata[6]) m_ferr = 1'b0;
      check_status("rnd_clr");
    end

    // Reset in the middle of a frame
    set_baud(16);
    send_frame(8'h5A, 1'b1);
    model_rx(8'h5A, 1'b1);
    rx = 1'b0;
    repeat (16 * 3) @(posedge clk);
    #1;
    do_reset();
    check_status("stat_midrst");
    apb_read(2'd2, rd, rdy);
    check_eq("baud_midrst", rd, 16'h01B2);
    set_baud(16);
    send_frame(8'hC3, 1'b1);
    model_rx(8'hC3, 1'b1);
    apb_read(2'd0, rd, rdy);
    check_eq("data_midrst", rd, model_pop());
    check_status("stat_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
